// File: rtl/comma_aligner_pkg.sv
// Shared definitions for the comma aligner and the downstream 8b/10b decoder:
// K28.5 code points, aligner FSM states and the symbol bit order.
package comma_aligner_pkg;

    // Symbol bit order: bit 0 = a (first bit on the line), bits 5:0 = abcdei,
    // bits 9:6 = fghj with bit 6 = f.
    localparam int SYM_W          = 10;
    localparam int SYM_A_BIT      = 0;
    localparam int SYM_ABCDEI_LSB = 0;
    localparam int SYM_ABCDEI_MSB = 5;
    localparam int SYM_FGHJ_LSB   = 6;
    localparam int SYM_FGHJ_MSB   = 9;

    // K28.5 in the bit order above, both running disparities.
    localparam logic [9:0] K28_5_NEG = 10'h17C;
    localparam logic [9:0] K28_5_POS = 10'h283;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // True when sym is either disparity of the comma character.
    function automatic logic is_k28_5(input logic [9:0] sym,
                                      input logic [9:0] neg,
                                      input logic [9:0] pos);
        return (sym == neg) || (sym == pos);
    endfunction

endpackage

// File: rtl/comma_aligner.sv
// Serial-to-symbol aligner: shifts recovered bits into a 10-bit window,
// locks the symbol boundary onto K28.5 commas and emits aligned symbols.
module comma_aligner #(
    parameter int         COMMA_TIMEOUT = 64,
    parameter logic [9:0] K28_5_NEG     = comma_aligner_pkg::K28_5_NEG,
    parameter logic [9:0] K28_5_POS     = comma_aligner_pkg::K28_5_POS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [9:0] sym_out,
    output logic       sym_valid,
    output logic       sym_is_comma,
    output logic       locked,
    output logic       align_err
);
    import comma_aligner_pkg::*;

    localparam int TMO_W = $clog2(COMMA_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(COMMA_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [9:0]       r_win;
    logic [9:0]       w_win_next;
    logic [3:0]       r_bit_cnt;
    logic [3:0]       w_bit_cnt_next;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] w_tmo_next;
    logic             w_comma_hit;
    logic             w_boundary;
    logic             w_emit;
    logic             w_emit_comma;
    logic             w_align_err;

    logic [9:0]       r_sym_out;
    logic             r_sym_valid;
    logic             r_sym_is_comma;
    logic             r_locked;
    logic             r_align_err;

    // New bits enter at the top so the oldest bit (a) ends up in bit 0.
    assign w_win_next  = {bit_in, r_win[9:1]};
    // Compare the window including the current bit: no added latency.
    assign w_comma_hit = bit_valid && is_k28_5(w_win_next, K28_5_NEG, K28_5_POS);
    assign w_boundary  = bit_valid && (r_bit_cnt == 4'd9);

    // State register: window, bit counter, timeout counter and FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_HUNT;
            r_win     <= 10'd0;
            r_bit_cnt <= 4'd0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tmo_cnt <= w_tmo_next;
            if (bit_valid) begin
                r_win <= w_win_next;
            end else begin
                r_win <= r_win;
            end
        end
    end

    // Next-state logic: comma handling takes priority over the lock timeout.
    always_comb begin
        w_state_next   = r_state;
        w_tmo_next     = r_tmo_cnt;
        w_bit_cnt_next = r_bit_cnt;
        if (bit_valid) begin
            if (r_bit_cnt == 4'd9) begin
                w_bit_cnt_next = 4'd0;
            end else begin
                w_bit_cnt_next = r_bit_cnt + 4'd1;
            end
        end else begin
            w_bit_cnt_next = r_bit_cnt;
        end
        case (r_state)
            ST_HUNT: begin
                if (w_comma_hit) begin
                    w_bit_cnt_next = 4'd0;
                    w_tmo_next     = '0;
                    w_state_next   = ST_VERIFY;
                end else begin
                    w_state_next   = ST_HUNT;
                end
            end
            ST_VERIFY, ST_LOCKED: begin
                if (w_comma_hit && w_boundary) begin
                    w_tmo_next     = '0;
                    w_state_next   = ST_LOCKED;
                end else if (w_comma_hit) begin
                    // Comma off the current boundary: realign on it.
                    w_bit_cnt_next = 4'd0;
                    w_tmo_next     = '0;
                    w_state_next   = ST_VERIFY;
                end else if (w_boundary) begin
                    if (r_tmo_cnt == TMO_LAST) begin
                        w_tmo_next   = '0;
                        w_state_next = ST_HUNT;
                    end else begin
                        w_tmo_next   = r_tmo_cnt + TMO_W'(1);
                    end
                end else begin
                    w_state_next = r_state;
                end
            end
            default: begin
                w_state_next   = ST_HUNT;
                w_bit_cnt_next = 4'd0;
                w_tmo_next     = '0;
            end
        endcase
    end

    // Output decode: what gets emitted this bit and whether it is a misaligned comma.
    always_comb begin
        w_emit       = 1'b0;
        w_emit_comma = 1'b0;
        w_align_err  = 1'b0;
        case (r_state)
            ST_HUNT: begin
                w_emit       = w_comma_hit;
                w_emit_comma = w_comma_hit;
            end
            ST_VERIFY, ST_LOCKED: begin
                w_emit       = w_comma_hit || w_boundary;
                w_emit_comma = w_comma_hit;
                w_align_err  = w_comma_hit && !w_boundary;
            end
            default: begin
                w_emit       = 1'b0;
                w_emit_comma = 1'b0;
                w_align_err  = 1'b0;
            end
        endcase
    end

    // Output register: strobes last one cycle, sym_out holds between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sym_out      <= 10'd0;
            r_sym_valid    <= 1'b0;
            r_sym_is_comma <= 1'b0;
            r_locked       <= 1'b0;
            r_align_err    <= 1'b0;
        end else begin
            r_sym_valid    <= w_emit;
            r_sym_is_comma <= w_emit_comma;
            r_align_err    <= w_align_err;
            r_locked       <= (r_state == ST_LOCKED);
            if (w_emit) begin
                r_sym_out <= w_win_next;
            end else begin
                r_sym_out <= r_sym_out;
            end
        end
    end

    assign sym_out      = r_sym_out;
    assign sym_valid    = r_sym_valid;
    assign sym_is_comma = r_sym_is_comma;
    assign locked       = r_locked;
    assign align_err    = r_align_err;

endmodule

// File: tb/tb_comma_aligner.sv
// Scoreboard bench for comma_aligner: stimulus pushes hand-computed expected
// symbols, an independent monitor pops and compares on every sym_valid.
module tb_comma_aligner;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic [9:0] sym_out;
    logic       sym_valid;
    logic       sym_is_comma;
    logic       locked;
    logic       align_err;

    typedef struct packed {
        logic [9:0] sym;
        logic       comma;
        logic       aerr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   vectors    = 0;
    int   miscompares = 0;
    int   strobes    = 0;
    int   gap        = 0;

    always #5 clk = ~clk;

    comma_aligner #(.COMMA_TIMEOUT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .sym_out      (sym_out),
        .sym_valid    (sym_valid),
        .sym_is_comma (sym_is_comma),
        .locked       (locked),
        .align_err    (align_err)
    );

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (sym_valid === 1'b1) begin
            strobes++;
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_symbol: got sym=0x%0h comma=%0b aerr=%0b, expected no symbol",
                         sym_out, sym_is_comma, align_err);
            end else begin
                mon_e = q.pop_front();
                if ({sym_out, sym_is_comma, align_err} !== {mon_e.sym, mon_e.comma, mon_e.aerr}) begin
                    miscompares++;
                    $display("FAIL symbol: got sym=0x%0h comma=%0b aerr=%0b, expected sym=0x%0h comma=%0b aerr=%0b",
                             sym_out, sym_is_comma, align_err, mon_e.sym, mon_e.comma, mon_e.aerr);
                end
            end
        end else if (sym_is_comma !== 1'b0 || align_err !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_flag: got comma=%0b aerr=%0b without sym_valid, expected 0/0",
                     sym_is_comma, align_err);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic expect_sym(input logic [9:0] v, input logic comma, input logic aerr);
        q.push_back({v, comma, aerr});
    endtask

    task automatic send_raw(input logic [9:0] v);
        for (int i = 0; i < 10; i++) begin
            send_bit(v[i]);
        end
    endtask

    task automatic send_sym(input logic [9:0] v, input logic comma, input logic aerr);
        expect_sym(v, comma, aerr);
        send_raw(v);
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sym_out"},   {22'd0, sym_out}, 32'h0);
        check({tag, "_sym_valid"}, {31'd0, sym_valid}, 32'h0);
        check({tag, "_locked"},    {31'd0, locked}, 32'h0);
        check({tag, "_align_err"}, {31'd0, align_err}, 32'h0);
    endtask

    int stray;
    int strobes_before;

    initial begin
        reset     = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;

        // Reset held with live, toggling input bits: nothing may come out.
        stray     = 0;
        bit_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bit_in = 1'($urandom);
            @(posedge clk); #1;
            if (sym_valid !== 1'b0 || locked !== 1'b0 || align_err !== 1'b0 || sym_out !== 10'd0)
                stray++;
        end
        check("reset_quiet", stray, 0);
        bit_valid = 1'b0;
        check_outputs_zero("reset");
        reset = 1'b0;
        idle(1);

        // Acquire on an RD- comma preceded by 7 zero bits.
        gap = 0;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_sym(10'h17C, 1'b1, 1'b0);
        check("comma_latency_valid", {31'd0, sym_valid}, 32'h1);
        check("comma_latency_sym", {22'd0, sym_out}, 32'h17C);
        check("verify_unlocked", {31'd0, locked}, 32'h0);
        send_sym(10'h0D4, 1'b0, 1'b0);
        send_sym(10'h2AA, 1'b0, 1'b0);
        idle(2);
        check("verify_still_unlocked", {31'd0, locked}, 32'h0);
        check("sym_out_holds", {22'd0, sym_out}, 32'h2AA);

        // Three data symbols then an aligned RD+ comma locks the link.
        send_sym(10'h155, 1'b0, 1'b0);
        send_sym(10'h333, 1'b0, 1'b0);
        send_sym(10'h1B6, 1'b0, 1'b0);
        send_sym(10'h283, 1'b1, 1'b0);
        check("lock_strobe_locked_low", {31'd0, locked}, 32'h0);
        idle(1);
        check("locked_after_comma", {31'd0, locked}, 32'h1);

        // Slip by 3 bits: the old boundary lands inside the comma (window
        // 1,0,1,0,0,1,1,1,1,1 = 0x3E5), then the comma flags align_err.
        expect_sym(10'h3E5, 1'b0, 1'b0);
        expect_sym(10'h17C, 1'b1, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_raw(10'h17C);
        check("slip_align_err", {31'd0, align_err}, 32'h1);
        check("slip_sym", {22'd0, sym_out}, 32'h17C);
        idle(1);
        check("slip_unlocked", {31'd0, locked}, 32'h0);
        check("slip_align_err_pulse", {31'd0, align_err}, 32'h0);
        send_sym(10'h0D4, 1'b0, 1'b0);
        send_sym(10'h249, 1'b0, 1'b0);
        send_sym(10'h283, 1'b1, 1'b0);
        idle(1);
        check("relocked", {31'd0, locked}, 32'h1);

        // Eight non-comma symbols: the 8th is emitted, then lock is lost.
        send_sym(10'h0D4, 1'b0, 1'b0);
        send_sym(10'h2AA, 1'b0, 1'b0);
        send_sym(10'h155, 1'b0, 1'b0);
        send_sym(10'h333, 1'b0, 1'b0);
        send_sym(10'h1B6, 1'b0, 1'b0);
        send_sym(10'h249, 1'b0, 1'b0);
        send_sym(10'h0D4, 1'b0, 1'b0);
        send_sym(10'h2AA, 1'b0, 1'b0);
        check("timeout_last_emitted", {31'd0, sym_valid}, 32'h1);
        check("timeout_still_locked", {31'd0, locked}, 32'h1);
        idle(1);
        check("timeout_unlocked", {31'd0, locked}, 32'h0);
        strobes_before = strobes;
        send_raw(10'h155);
        send_raw(10'h333);
        idle(1);
        check("hunt_silent", strobes - strobes_before, 0);
        send_sym(10'h17C, 1'b1, 1'b0);
        idle(1);
        check("reacquire_verify", {31'd0, locked}, 32'h0);

        // Same stream with one bit every third cycle.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        gap   = 2;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_sym(10'h17C, 1'b1, 1'b0);
        send_sym(10'h0D4, 1'b0, 1'b0);
        send_sym(10'h2AA, 1'b0, 1'b0);
        send_sym(10'h155, 1'b0, 1'b0);
        send_sym(10'h333, 1'b0, 1'b0);
        send_sym(10'h1B6, 1'b0, 1'b0);
        send_sym(10'h283, 1'b1, 1'b0);
        check("gapped_locked", {31'd0, locked}, 32'h1);

        // Reset five bits into a symbol: partial symbol dropped, back to HUNT.
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        reset = 1'b1;
        idle(2);
        check_outputs_zero("midreset");
        reset = 1'b0;
        strobes_before = strobes;
        send_raw(10'h0D4);
        check("post_reset_hunt", strobes - strobes_before, 0);
        send_sym(10'h17C, 1'b1, 1'b0);
        send_sym(10'h0D4, 1'b0, 1'b0);
        send_sym(10'h2AA, 1'b0, 1'b0);
        send_sym(10'h283, 1'b1, 1'b0);
        idle(1);
        check("post_reset_relock", {31'd0, locked}, 32'h1);

        // Drain: every expected symbol must have been seen.
        for (int t = 0; t < 20 && q.size() != 0; t++) idle(1);
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
- Sits between the BPSK demodulator's recovered bit stream and the 8b/10b symbol decoder.
- Assembles serial bits into 10-bit symbols.
- Finds symbol boundaries from the K28.5 comma and tracks lock.
- Presents each aligned symbol as {fghj, abcdei}: bit 0 = a (first received bit), bits 5:0 = abcdei, bits 9:6 = fghj (bit 6 = f).

Parameters:
- COMMA_TIMEOUT, 64: consecutive non-comma symbols tolerated before lock is dropped (range 2..1023).
- K28_5_NEG, 10'h17C: K28.5 RD- (abcdei=001111, fghj=1010) in output bit order.
- K28_5_POS, 10'h283: K28.5 RD+ (abcdei=110000, fghj=0101) in output bit order.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- bit_in  in  1  recovered serial data bit, LSB-first (a first)
- bit_valid  in  1  bit_in qualifier, one bit per asserted cycle
- sym_out  out  10  aligned symbol to decoder; holds last value between strobes
- sym_valid  out  1  one-cycle strobe: new symbol on sym_out
- sym_is_comma  out  1  qualifies sym_valid: symbol is K28.5 (either disparity)
- locked  out  1  high only in LOCKED state
- align_err  out  1  one-cycle pulse: comma found off the current boundary while in VERIFY or LOCKED

Behaviour:
- Clocking and reset: clk; reset is synchronous and active-high. Reset clears the window, bit_cnt, tmo_cnt, state=HUNT, and every output to 0. Reset mid-symbol discards the partial symbol.
- Window: on bit_valid, win_next = {bit_in, win[9:1]}, win <= win_next. With bit_valid low, all state and outputs hold, and the strobes are 0.
- comma_hit = bit_valid && (win_next == K28_5_NEG || win_next == K28_5_POS). The compare uses win_next, so there is no bit of latency. The zero-filled window after reset never matches.
- bit_cnt: 0..9, advances on bit_valid. boundary = bit_valid && bit_cnt == 9. It wraps 9 -> 0.
- Outputs are registered. sym_out, sym_valid and sym_is_comma update the cycle after the bit_valid that completes the symbol (latency 1 clk from the last bit).
- FSM, HUNT:
  - No symbols are emitted.
  - On comma_hit: emit win_next with is_comma=1, bit_cnt <= 0 (the next bit starts a new symbol), tmo_cnt <= 0, go to VERIFY.
- FSM, VERIFY:
  - Emit every boundary symbol.
  - Aligned comma (comma_hit && boundary): emit it, tmo_cnt <= 0, go to LOCKED.
  - Off-boundary comma_hit: pulse align_err, emit the comma, realign bit_cnt <= 0, tmo_cnt <= 0, stay in VERIFY.
- FSM, LOCKED:
  - Emit every boundary symbol.
  - Aligned comma: tmo_cnt <= 0.
  - Off-boundary comma_hit: pulse align_err, emit the comma, realign, go to VERIFY (locked falls next cycle).
- Timeout (VERIFY and LOCKED):
  - A non-comma boundary increments tmo_cnt.
  - If that symbol is the COMMA_TIMEOUT-th consecutive non-comma symbol, it is still emitted, then state goes to HUNT and tmo_cnt <= 0.
  - Priority when the same cycle qualifies for several actions: comma (aligned or not) > timeout.
- locked is registered and equals (state == LOCKED) one cycle after the transition.
- tmo_cnt width is $clog2(COMMA_TIMEOUT+1) and it never wraps.
- sym_is_comma is 0 whenever sym_valid is 0.

Decomposition:
- Shared package: K28_5_NEG/K28_5_POS constants, the FSM state typedef (HUNT, VERIFY, LOCKED) and the symbol bit-order definition. The downstream decoder reuses the same bit-order definition.
- Single module, no sub-module. The comparator is two 10-bit equality checks.

Test Plan:
- Reset with bit_in toggling and bit_valid=1 -> all outputs 0, no sym_valid for 50 cycles of non-comma random bits.
- 7 zero bits, then 0x17C LSB-first, then 0x0D4, 0x2AA -> sym_valid 1 clk after the comma's 10th bit with sym_out=0x17C and is_comma=1; then 0x0D4 and 0x2AA each 10 bits later; locked=0.
- Continue with 3 data symbols then an aligned 0x283 -> sym_out=0x283, is_comma=1; locked=1 the cycle after the strobe.
- While LOCKED, insert 3 extra bits then 0x17C -> align_err pulse, sym_out=0x17C, locked=0; the following symbols decode correctly at the new boundary.
- COMMA_TIMEOUT=8, locked, send 8 data symbols without a comma -> the 8th is still emitted, then locked=0 and there is no further sym_valid until a comma arrives.
- bit_valid asserted every 3rd cycle, same stream as the second scenario -> identical symbol sequence; assert reset after 5 bits of a symbol -> outputs 0, state HUNT, and the next comma re-acquires lock.
